// File: rtl/sti_rx_pkg.sv
// Shared types for the serial receive packer: FSM states, byte type, bit-order encoding.
package sti_rx_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic BIT_ORDER_LSB = 1'b0;
  localparam logic BIT_ORDER_MSB = 1'b1;

  // One serial bit into the partial byte; after eight calls the first bit sits
  // in bit 7 (MSB-first) or bit 0 (LSB-first).
  function automatic byte_t shift_in(byte_t cur, logic b, logic order);
    byte_t res;
    case (order)
      BIT_ORDER_MSB: res = {cur[6:0], b};
      BIT_ORDER_LSB: res = {b, cur[7:1]};
      default:       res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sti_rx_fifo.sv
// Synchronous byte FIFO; a push into a full FIFO is taken only when a pop happens on the same edge.
module sti_rx_fifo
  import sti_rx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  byte_t push_data_i,
  input  logic  pop_i,
  output byte_t head_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  byte_t       mem_q [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/sti_rx_packer.sv
// Packs the transmitter bit stream into bytes, buffers them and writes them to sequential memory addresses.
// Build option STI_RX_ZERO_FILL_EN: pad all unwritten addresses with 0x00 before raising done.
module sti_rx_packer
  import sti_rx_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_data,
  input  logic              rx_valid,
  input  logic              rx_msb,
  input  logic              rx_end,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              done,
  output logic              ovf,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  byte_t             sr_q, sr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              mem_full_q, mem_full_d;
  logic              done_q;
  logic              ovf_q, ovf_d;
  logic              ferr_q, ferr_d;

  byte_t fifo_head;
  logic  fifo_full;
  logic  fifo_empty;
  logic  fifo_push;
  logic  fifo_pop;
  byte_t byte_next;
  logic  byte_done;
  logic  wr_phase;
  logic  fill_phase;
  logic  wr_fire;
  logic  drop_head;

  assign byte_next = shift_in(sr_q, rx_data, rx_msb);
  assign byte_done = (state_q == ST_RUN) && rx_valid && (cnt_q == 3'd7);
  assign wr_phase  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

`ifdef STI_RX_ZERO_FILL_EN
  assign fill_phase = (state_q == ST_FILL);
`else
  assign fill_phase = 1'b0;
`endif

  // Write handshake: a write completes on an edge where mem_we and mem_ready are both high.
  assign mem_we    = !mem_full_q && ((wr_phase && !fifo_empty) || fill_phase);
  assign mem_wdata = (wr_phase && mem_we) ? fifo_head : 8'h00;
  assign mem_addr  = addr_q;
  assign wr_fire   = mem_we && mem_ready;

  // Once the memory is full, buffered bytes have nowhere to go and are discarded one per cycle.
  assign drop_head = wr_phase && mem_full_q && !fifo_empty;
  assign fifo_pop  = (wr_phase && wr_fire) || drop_head;
  assign fifo_push = byte_done && !mem_full_q;

  sti_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .rst_ni      (reset),
    .push_i      (fifo_push),
    .push_data_i (byte_next),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    sr_d   = sr_q;
    cnt_d  = cnt_q;
    ferr_d = ferr_q;
    if (state_q == ST_RUN) begin
      if (rx_valid) begin
        sr_d  = byte_next;
        cnt_d = cnt_q + 3'd1;
      end else if (cnt_q != 3'd0) begin
        sr_d   = '0;
        cnt_d  = '0;
        ferr_d = 1'b1;
      end
    end else if (cnt_q != 3'd0) begin
      // Leftover bits when capture stops at end-of-stream.
      sr_d   = '0;
      cnt_d  = '0;
      ferr_d = 1'b1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop_head) ovf_d = 1'b1;
    if (byte_done && (mem_full_q || (fifo_full && !fifo_pop))) ovf_d = 1'b1;
  end

  always_comb begin
    addr_d     = addr_q;
    mem_full_d = mem_full_q;
    if (wr_fire) begin
      if (addr_q == ADDR_LAST) mem_full_d = 1'b1;
      else                     addr_d     = addr_q + ADDR_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (rx_end) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
`ifdef STI_RX_ZERO_FILL_EN
        if (fifo_empty) state_d = ST_FILL;
`else
        if (fifo_empty) state_d = ST_DONE;
`endif
      end
      ST_FILL: begin
`ifdef STI_RX_ZERO_FILL_EN
        if (mem_full_q || (wr_fire && (addr_q == ADDR_LAST))) state_d = ST_DONE;
`else
        state_d = ST_DONE;
`endif
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      sr_q       <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      mem_full_q <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      mem_full_q <= mem_full_d;
      done_q     <= (state_q == ST_DONE);
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
    end
  end

  assign done      = done_q;
  assign ovf       = ovf_q;
  assign frame_err = ferr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sti_rx_packer.sv
// Directed and randomized bench for sti_rx_packer; the expected write stream comes from a byte-level model.
module tb_sti_rx_packer;

  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_SIZE   = 1 << ADDR_W;
  localparam int W          = ADDR_W + 8;

  logic              clk;
  logic              reset;
  logic              rx_data;
  logic              rx_valid;
  logic              rx_msb;
  logic              rx_end;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              done;
  logic              ovf;
  logic              frame_err;
  logic [1:0]        dbg_state;

  sti_rx_packer #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_msb    (rx_msb),
    .rx_end    (rx_end),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .ovf       (ovf),
    .frame_err (frame_err),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int              n_checks;
  int              n_errors;
  int              n_extra;
  int              model_cnt;
  int              ready_mode;
  int              cyc;
  logic [W-1:0]    exp_q[$];
  logic            exp_ovf;
  logic            exp_ferr;
  logic            prev_stall;
  logic [ADDR_W-1:0] prev_addr;
  logic [7:0]      prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every completed write must match the head of the expected queue
  task automatic monitor();
    logic [W-1:0] exp_w;
    if (prev_stall) begin
      check("stall_addr", 32'(mem_addr), 32'(prev_addr));
      check("stall_data", 32'(mem_wdata), 32'(prev_data));
    end
    prev_stall = mem_we && !mem_ready;
    prev_addr  = mem_addr;
    prev_data  = mem_wdata;
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) n_extra++;
      else begin
        exp_w = exp_q.pop_front();
        check("write", 32'({mem_addr, mem_wdata}), 32'(exp_w));
      end
    end
  endtask

  // driver: one clock per call, inputs change 1 time unit after the rising edge
  task automatic cycle(input logic v, input logic d, input logic e);
    @(posedge clk);
    #1;
    rx_valid = v;
    rx_data  = d;
    rx_end   = e;
    cyc++;
    case (ready_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = (cyc % 4 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      default: mem_ready = 1'b0;
    endcase
    @(negedge clk);
    monitor();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic msb, input logic last_end);
    rx_msb = msb;
    for (int i = 0; i < 8; i++)
      cycle(1'b1, msb ? b[7-i] : b[i], (i == 7) ? last_end : 1'b0);
  endtask

  // reference model: accepted bytes go to consecutive addresses until memory is full
  task automatic model_byte(input logic [7:0] b);
    logic [ADDR_W-1:0] a;
    if (model_cnt < MEM_SIZE) begin
      a = ADDR_W'(model_cnt);
      exp_q.push_back({a, b});
      model_cnt++;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic model_fill();
`ifdef STI_RX_ZERO_FILL_EN
    for (int a = model_cnt; a < MEM_SIZE; a++) exp_q.push_back({ADDR_W'(a), 8'h00});
`endif
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 1'b0;
    rx_end    = 1'b0;
    mem_ready = 1'b0;
    exp_q.delete();
    model_cnt  = 0;
    exp_ovf    = 1'b0;
    exp_ferr   = 1'b0;
    prev_stall = 1'b0;
    n_extra    = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic end_checks();
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("extra_writes", 32'(n_extra), 32'd0);
    check("ovf", 32'(ovf), 32'(exp_ovf));
    check("frame_err", 32'(frame_err), 32'(exp_ferr));
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done; k++) cycle(1'b0, 1'b0, 1'b0);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"},    32'(mem_we),    32'd0);
    check({tag, "_addr"},  32'(mem_addr),  32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_done"},  32'(done),      32'd0);
    check({tag, "_ovf"},   32'(ovf),       32'd0);
    check({tag, "_ferr"},  32'(frame_err), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       msb;
    int         n;

    reset      = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 1'b0;
    rx_msb     = 1'b0;
    rx_end     = 1'b0;
    mem_ready  = 1'b0;
    ready_mode = 0;
    exp_ovf    = 1'b0;
    exp_ferr   = 1'b0;
    prev_stall = 1'b0;
    #3;
    check_reset_values("reset");
    do_reset();

    // LSB-first 0xA5, write visible the cycle after the 8th bit
    send_byte(8'hA5, 1'b0, 1'b0);
    check("lat_before", 32'(mem_we), 32'd0);
    model_byte(8'hA5);
    cycle(1'b0, 1'b0, 1'b0);
    check("lat_we", 32'(mem_we), 32'd1);
    check("lat_addr", 32'(mem_addr), 32'd0);
    check("lat_data", 32'(mem_wdata), 32'hA5);
    idle(4);
    end_checks();

    // MSB-first 16-bit frame 0x1234
    do_reset();
    send_byte(8'h12, 1'b1, 1'b0);
    model_byte(8'h12);
    send_byte(8'h34, 1'b1, 1'b0);
    model_byte(8'h34);
    idle(4);
    end_checks();
    check("addr_after_2", 32'(mem_addr), 32'd2);

    // memory stalled for five bytes: four buffered, fifth dropped
    do_reset();
    ready_mode = 2;
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b0, 1'b0);
      if (k < FIFO_DEPTH) model_byte(b);
      else exp_ovf = 1'b1;
    end
    idle(1);
    check("ovf_fifo_full", 32'(ovf), 32'd1);
    ready_mode = 0;
    idle(8);
    end_checks();

    // partial frame discarded, next frame still correct
    do_reset();
    rx_msb = 1'b1;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    idle(2);
    exp_ferr = 1'b1;
    check("ferr_set", 32'(frame_err), 32'd1);
    check("ferr_no_write", 32'(mem_we), 32'd0);
    b = 8'($urandom);
    send_byte(b, 1'b1, 1'b0);
    model_byte(b);
    idle(4);
    end_checks();
    check("ferr_addr", 32'(mem_addr), 32'd1);

    // three bytes, then three stray bits ending with rx_end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      send_byte(b, 1'b0, 1'b0);
      model_byte(b);
    end
    idle(3);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1);
    exp_ferr = 1'b1;
    model_fill();
`ifdef STI_RX_ZERO_FILL_EN
    wait_done(60);
`else
    check("done_at_0", 32'(done), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("done_at_1", 32'(done), 32'd0);
    cycle(1'b0, 1'b0, 1'b0);
    check("done_at_2a", 32'(done), 32'd0);
    check("state_done", 32'(dbg_state), 32'd3);
    cycle(1'b0, 1'b0, 1'b0);
    check("done_at_2", 32'(done), 32'd1);
`endif
    idle(3);
    check("done_held", 32'(done), 32'd1);
    check("done_no_we", 32'(mem_we), 32'd0);
    end_checks();

    // randomized streams, the first one overrunning the memory
    for (int run = 0; run < 3; run++) begin
      do_reset();
      ready_mode = 1;
      msb = 1'($urandom_range(0, 1));
      n = (run == 0) ? MEM_SIZE + 2 : $urandom_range(4, MEM_SIZE);
      for (int k = 0; k < n; k++) begin
        idle($urandom_range(0, 2));
        b = 8'($urandom);
        send_byte(b, msb, (k == n - 1) ? 1'b1 : 1'b0);
        model_byte(b);
      end
      model_fill();
      wait_done(300);
      idle(2);
      check("rand_done_we", 32'(mem_we), 32'd0);
      end_checks();
    end

    // reset in the middle of a frame with a write pending
    do_reset();
    ready_mode = 2;
    send_byte(8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0);
    check("pre_reset_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    do_reset();
    check_reset_values("rst_release");
    ready_mode = 0;
    b = 8'($urandom);
    send_byte(b, 1'b1, 1'b0);
    model_byte(b);
    idle(4);
    end_checks();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sti_rx_packer.md
# sti_rx_packer

Downstream stage of the serial transmitter. Consumes its bit stream (`so_data`/`so_valid`) and re-packs the bits into bytes. Buffers the bytes in a small FIFO and writes them to sequential addresses of a byte-wide result memory through a ready-qualified write port. On end-of-stream it drains, optionally zero-fills the rest of memory, and signals completion.

## Interface
- `ADDR_W`, 8: result memory address width (depth 2^ADDR_W bytes)
- `FIFO_DEPTH`, 4: byte FIFO entries (power of two, ≥2)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `rx_data` in 1: serial bit, driven by transmitter `so_data`
- `rx_valid` in 1: bit qualifier, driven by transmitter `so_valid`
- `rx_msb` in 1: 1 = stream arrives MSB-first, 0 = LSB-first
- `rx_end` in 1: single-cycle pulse, no further frames follow
- `mem_ready` in 1: memory accepts a write this cycle
- `mem_we` out 1: write request
- `mem_addr` out ADDR_W: write address
- `mem_wdata` out 8: write data
- `done` out 1: completion, held until reset
- `ovf` out 1: sticky; byte dropped (FIFO full or memory full)
- `frame_err` out 1: sticky; partial byte discarded

## Operation
- Bit capture: each rising edge with `rx_valid`=1 samples `rx_data` into an 8-bit shift register.
  - MSB-first: first bit lands in byte bit 7.
  - LSB-first: first bit lands in byte bit 0.
  - A 3-bit counter tracks received bits.
- A 16-bit frame yields two bytes, first-received byte first.
- When the 8th bit is sampled, the completed byte (including that bit) is pushed into the FIFO on the same edge. The counter wraps to 0.
- If `rx_valid` is 0 while the counter is non-zero:
  - discard the partial byte;
  - set the counter to 0;
  - set `frame_err`.
- FSM states: RUN, DRAIN, FILL, DONE. Reset state is RUN.
  - RUN: capture and write. `rx_end`=1 → DRAIN. A bit sampled in the same cycle as `rx_end` is still accepted.
  - DRAIN: capture ignored. A non-zero bit counter on entry sets `frame_err`. Go to FILL when the FIFO is empty (macro defined), else DONE.
  - FILL: `mem_wdata`=0x00, `mem_we`=1. Writes every remaining address through 2^ADDR_W−1. After the last accepted write → DONE.
  - DONE: `done`=1, `mem_we`=0. Remains here until reset.
- Write port (RUN/DRAIN):
  - `mem_we` = FIFO non-empty and memory not full.
  - `mem_wdata` = FIFO head.
  - A write completes on an edge where `mem_we`&&`mem_ready`: pop FIFO, `mem_addr`+1.
- Memory full: set after the write to address 2^ADDR_W−1 completes. Afterwards, every FIFO entry and new byte is dropped and sets `ovf`. `mem_addr` does not wrap.
- FIFO full with a push and no pop in the same cycle: byte dropped, `ovf` set. Push and pop in the same cycle while full is legal, with no drop.

## Timing
- Reset values: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `ovf`=0, `frame_err`=0. FIFO empty, counter 0, state RUN.
- Reset asserted mid-operation aborts immediately; no partial write is retried.
- Latency: 8th bit sampled at edge N → `mem_we`=1 during cycle N+1 (FIFO was empty, memory not full).
- With `mem_ready` held high, sustained throughput is 1 byte per cycle, against 1 byte per 8 cycles of input.
- `mem_addr`/`mem_wdata` are stable while `mem_we`=1 and `mem_ready`=0.
- `done` rises the cycle after the state enters DONE. With an empty FIFO and the macro undefined, that is 2 cycles after `rx_end`.

## Configuration
- `STI_RX_ZERO_FILL_EN`:
  - Defined: the FILL state exists and pads all unwritten addresses with 0x00 before `done`.
  - Undefined: DRAIN goes straight to DONE and unwritten memory is untouched.

## Structure
- Package `sti_rx_pkg`: FSM state enum (RUN, DRAIN, FILL, DONE), byte typedef, bit-order constants.
- Sub-module `sti_rx_fifo`: synchronous byte FIFO with push/pop/full/empty and same-cycle push-pop while full.

## Test plan
- LSB-first 8-bit frame, bits of 0xA5, `mem_ready`=1 → one write, addr 0, data 0xA5, `mem_we` high the cycle after the 8th bit.
- MSB-first 16-bit frame of 0x1234 → writes addr 0 = 0x12, addr 1 = 0x34.
- `mem_ready`=0 for 40 cycles during five bytes (FIFO_DEPTH=4) → first four bytes written in order, fifth dropped, `ovf`=1.
- `rx_valid` drops after 5 bits → no write, `frame_err`=1; the next full frame is still written correctly.
- ADDR_W=4, three bytes then `rx_end` with the macro defined → addr 3..15 written 0x00, `done`=1. Without the macro, `done`=1 two cycles after `rx_end` and only 3 writes occur.
- Reset asserted mid-frame → all outputs at reset values next edge; the following frame lands at addr 0.
